// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//   Client-side bundle of the RAM port arbiter. Each requester packs its
//   command into the flat vectors at [i*W +: W].
//   master : client logic (drives req/req_we/req_addr/req_data)
//   slave  : arbiter      (drives gnt/done/rdata/busy)
//   req       NUM_REQ             request level per requester
//   req_we    NUM_REQ             1=write, 0=read
//   req_addr  NUM_REQ*ADDR_WIDTH  flat address vector
//   req_data  NUM_REQ*DATA_WIDTH  flat write data vector
//   gnt       NUM_REQ             one-hot grant pulse
//   done      NUM_REQ             one-hot completion pulse
//   rdata     DATA_WIDTH          read data, valid with done of a read
//   busy      1                   arbiter not idle
interface ram_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 5
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [DATA_WIDTH-1:0]         rdata;
    logic                          busy;

    modport master (
        output req, req_we, req_addr, req_data,
        input  gnt, done, rdata, busy
    );

    modport slave (
        input  req, req_we, req_addr, req_data,
        output gnt, done, rdata, busy
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port RAM (registered output) between NUM_REQ clients
//   using round-robin arbitration. The command is captured at grant and
//   sequenced onto the RAM port; completion is signalled with a done pulse.
//   clk       clock, rising edge
//   reset_n   async active-low reset
//   bus       client interface (slave modport)
//   ram_addr  RAM address, registered
//   ram_data  RAM write data, registered
//   ram_we    RAM write enable, registered
//   ram_out   RAM read data (registered inside the RAM)
//
// state  | meaning
// IDLE   | waiting for any request; grants the round-robin winner
// ISSUE  | RAM samples ram_*; writes complete here
// RDWAIT | ram_out valid; read data captured and read completes
module ram_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    ram_port_arbiter_if.slave     bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_out
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] cand;
    logic             found;

    // Search upward from ptr+1 with wrap, so the last winner is checked last.
    always_comb begin
        win   = ptr;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= PTR_W'(NUM_REQ - 1);
            bus.gnt   <= '0;
            bus.done  <= '0;
            bus.rdata <= '0;
            ram_addr  <= '0;
            ram_data  <= '0;
            ram_we    <= 1'b0;
        end else begin
            bus.gnt  <= '0;
            bus.done <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        ram_addr <= bus.req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                        ram_data <= bus.req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                        ram_we   <= bus.req_we[win];
                        bus.gnt  <= NUM_REQ'(1) << win;
                        ptr      <= win;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_we <= 1'b0;
                    if (ram_we) begin
                        bus.done <= NUM_REQ'(1) << ptr;
                        state    <= IDLE;
                    end else begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    bus.rdata <= ram_out;
                    bus.done  <= NUM_REQ'(1) << ptr;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] ram_addr;
    logic [4:0] ram_data;
    logic       ram_we;
    logic [4:0] ram_out;
    logic [4:0] mem [0:31];
    int         errors = 0;
    int         checks = 0;
    int         order [5] = '{0, 1, 2, 3, 0};

    ram_port_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(5), .DATA_WIDTH(5)) bus ();

    ram_port_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(5), .DATA_WIDTH(5)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_we   (ram_we),
        .ram_out  (ram_out)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered output.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        ram_out = '0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_out <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [4:0] a, input logic [4:0] d);
        bus.req_addr[i*5 +: 5] = a;
        bus.req_data[i*5 +: 5] = d;
    endtask

    // A write enable may only be seen in the ISSUE cycle, which is the grant cycle.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && ram_we === 1'b1)
            chk("we_only_in_issue", {31'd0, bus.gnt != 4'd0}, 32'd1);
    end

    initial begin
        // 1: reset with all requests high
        reset_n      = 1'b0;
        bus.req      = 4'b1111;
        bus.req_we   = 4'b0000;
        bus.req_addr = '0;
        bus.req_data = '0;
        tick();
        tick();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_data", ram_data, 0);
        chk("rst_ram_we", ram_we, 0);
        reset_n = 1'b1;
        tick();
        chk("rel_gnt", bus.gnt, 4'b0001);
        chk("rel_busy", bus.busy, 1);
        bus.req = 4'b0000;
        tick();
        chk("rel_gnt_clear", bus.gnt, 0);
        tick();
        chk("rel_done", bus.done, 4'b0001);
        chk("rel_idle", bus.busy, 0);

        // 2: write 0x15 to addr 3, then read it back
        set_slot(0, 5'd3, 5'h15);
        bus.req_we = 4'b0001;
        bus.req    = 4'b0001;
        tick();
        chk("wr_gnt", bus.gnt, 4'b0001);
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, 3);
        chk("wr_ram_data", ram_data, 5'h15);
        bus.req = 4'b0000;
        set_slot(0, 5'd9, 5'h01);
        tick();
        chk("wr_done", bus.done, 4'b0001);
        chk("wr_ram_we_off", ram_we, 0);
        chk("wr_gnt_off", bus.gnt, 0);
        set_slot(0, 5'd3, 5'h00);
        bus.req_we = 4'b0000;
        bus.req    = 4'b0001;
        tick();
        chk("rd_gnt", bus.gnt, 4'b0001);
        chk("rd_ram_we", ram_we, 0);
        chk("rd_ram_addr", ram_addr, 3);
        bus.req = 4'b0000;
        tick();
        chk("rd_no_early_done", bus.done, 0);
        tick();
        chk("rd_done", bus.done, 4'b0001);
        chk("rd_rdata", bus.rdata, 5'h15);

        // 5: reset during ISSUE of a write
        set_slot(1, 5'd10, 5'h1F);
        bus.req_we = 4'b0010;
        bus.req    = 4'b0010;
        tick();
        chk("mr_gnt", bus.gnt, 4'b0010);
        chk("mr_we_high", ram_we, 1);
        bus.req = 4'b0000;
        #2 reset_n = 1'b0;
        #1;
        chk("mr_we_async", ram_we, 0);
        chk("mr_busy", bus.busy, 0);
        tick();
        chk("mr_no_done", bus.done, 0);
        reset_n = 1'b1;
        tick();
        chk("mr_idle", bus.busy, 0);
        chk("mr_no_write", mem[10], 0);

        // 3: round robin with all requesters reading continuously
        for (int i = 0; i < 4; i++) set_slot(i, 5'(i), 5'd0);
        bus.req_we = 4'b0000;
        bus.req    = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk($sformatf("rr_gnt%0d", n), bus.gnt, 4'b0001 << order[n]);
            if (n == 4) bus.req = 4'b0000;
            tick();
            chk($sformatf("rr_gap%0d", n), bus.gnt | bus.done, 0);
            tick();
            chk($sformatf("rr_done%0d", n), bus.done, 4'b0001 << order[n]);
            chk($sformatf("rr_rdata%0d", n), bus.rdata, (order[n] == 3) ? 5'h15 : 5'h00);
        end

        // 4: priority wrap after requester 3 wins
        bus.req = 4'b1000;
        tick();
        chk("pw_gnt3", bus.gnt, 4'b1000);
        bus.req = 4'b0000;
        tick();
        tick();
        chk("pw_done3", bus.done, 4'b1000);
        bus.req = 4'b1001;
        tick();
        chk("pw_gnt0", bus.gnt, 4'b0001);
        tick();
        tick();
        chk("pw_done0", bus.done, 4'b0001);
        tick();
        chk("pw_gnt3b", bus.gnt, 4'b1000);
        bus.req = 4'b0000;
        tick();
        tick();
        chk("pw_done3b", bus.done, 4'b1000);
        chk("pw_rdata", bus.rdata, 5'h15);

        // 6: requester 1 writes addr 7, requester 2 reads it
        set_slot(1, 5'd7, 5'h0A);
        set_slot(2, 5'd7, 5'h00);
        bus.req_we = 4'b0010;
        bus.req    = 4'b0010;
        tick();
        chk("hz_wgnt", bus.gnt, 4'b0010);
        chk("hz_waddr", ram_addr, 7);
        chk("hz_wdata", ram_data, 5'h0A);
        bus.req = 4'b0000;
        tick();
        chk("hz_wdone", bus.done, 4'b0010);
        chk("hz_rdata_hold", bus.rdata, 5'h15);
        bus.req_we = 4'b0000;
        bus.req    = 4'b0100;
        tick();
        chk("hz_rgnt", bus.gnt, 4'b0100);
        chk("hz_r_we", ram_we, 0);
        bus.req = 4'b0000;
        tick();
        tick();
        chk("hz_rdone", bus.done, 4'b0100);
        chk("hz_rdata", bus.rdata, 5'h0A);
        tick();
        chk("hz_idle", bus.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
